// File: rtl/cabac_mvd_pkg.sv
// Shared types and constants for the CABAC mvd neighbour-context block.
// Holds the state encoding, ctx thresholds and the |mvd| saturation helper.
package cabac_mvd_pkg;

    localparam int FMV_WIDTH     = 8;
    localparam int MEM_TOP_DEPTH = 7;
    localparam int CTX_LO        = 3;
    localparam int CTX_HI        = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        OUT,
        WR
    } state_t;

    // |v| clipped to max_v; -32768 is widened first so it does not wrap.
    function automatic logic [16:0] abs_sat(
        input logic signed [15:0] v,
        input logic [16:0]        max_v
    );
        logic signed [16:0] e;
        logic [16:0]        m;
        e = {v[15], v};
        m = e[16] ? $unsigned(-e) : $unsigned(e);
        return (m > max_v) ? max_v : m;
    endfunction

endpackage

// File: rtl/cabac_mvd_nb_ctx_if.sv
// MB-side handshake bundle of the mvd neighbour manager.
// The master drives MB start/done, the slave returns the contexts.
interface cabac_mvd_nb_ctx_if #(
    parameter int MEM_TOP_DEPTH = 7
);
    logic                     mb_start_i;
    logic [MEM_TOP_DEPTH-1:0] mb_x_i;
    logic [15:0]              mb_y_i;
    logic                     nb_valid_o;
    logic [1:0]               ctx_inc_x_o;
    logic [1:0]               ctx_inc_y_o;
    logic                     mb_done_i;
    logic                     mvd_zero_i;
    logic signed [15:0]       cur_mvd_x_i;
    logic signed [15:0]       cur_mvd_y_i;

    modport master (
        output mb_start_i, mb_x_i, mb_y_i,
        output mb_done_i, mvd_zero_i,
        output cur_mvd_x_i, cur_mvd_y_i,
        input  nb_valid_o, ctx_inc_x_o, ctx_inc_y_o
    );

    modport slave (
        input  mb_start_i, mb_x_i, mb_y_i,
        input  mb_done_i, mvd_zero_i,
        input  cur_mvd_x_i, cur_mvd_y_i,
        output nb_valid_o, ctx_inc_x_o, ctx_inc_y_o
    );
endinterface

// File: rtl/cabac_mvd_ctx_calc.sv
// ctxIdxInc for mvd bin0 from the two neighbour magnitudes.
// The sum is one bit wider than the inputs so it never wraps.
module cabac_mvd_ctx_calc
    import cabac_mvd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] abs_a,
    input  logic [W-1:0] abs_b,
    output logic [1:0]   ctx
);
    localparam logic [W:0] LO = CTX_LO[W:0];
    localparam logic [W:0] HI = CTX_HI[W:0];

    logic [W:0] sum;

    // Classify the neighbour sum into the three bin0 contexts.
    always_comb begin
        sum = {1'b0, abs_a} + {1'b0, abs_b};
        ctx = 2'd0;
        if (sum > HI) begin
            ctx = 2'd2;
        end else if (sum >= LO) begin
            ctx = 2'd1;
        end
    end
endmodule

// File: rtl/cabac_mvd_nb_ctx.sv
// Neighbour manager for CABAC mvd context selection: fetches the top |mvd|
// pair from the row RAM, keeps the left pair, writes back on MB completion.
module cabac_mvd_nb_ctx #(
    parameter int FMV_WIDTH     = cabac_mvd_pkg::FMV_WIDTH,
    parameter int MEM_TOP_DEPTH = cabac_mvd_pkg::MEM_TOP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cabac_mvd_nb_ctx_if.slave          mb,
    output logic                       r_en_o,
    output logic [MEM_TOP_DEPTH-1:0]   r_addr_o,
    input  logic [2*(FMV_WIDTH+1)-1:0] r_data_i,
    output logic                       w_en_o,
    output logic [MEM_TOP_DEPTH-1:0]   w_addr_o,
    output logic [2*(FMV_WIDTH+1)-1:0] w_data_o
);
    import cabac_mvd_pkg::*;

    localparam int          W       = FMV_WIDTH + 1;
    localparam logic [16:0] SAT_MAX = 17'((1 << W) - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [MEM_TOP_DEPTH-1:0] mb_x_q;
    logic                     top_avail_q;
    logic [W-1:0]             left_x_q;
    logic [W-1:0]             left_y_q;
    logic [W-1:0]             pair_x_q;
    logic [W-1:0]             pair_y_q;
    logic [1:0]               ctx_x_q;
    logic [1:0]               ctx_y_q;
    logic [W-1:0]             top_x;
    logic [W-1:0]             top_y;
    logic [W-1:0]             left_x;
    logic [W-1:0]             left_y;
    logic [1:0]               ctx_x;
    logic [1:0]               ctx_y;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one read cycle, one wait cycle, hold until done, one write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mb.mb_start_i) state_d = RD;
            RD:      state_d = WT;
            WT:      state_d = OUT;
            OUT:     if (mb.mb_done_i) state_d = WR;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Neighbours masked to zero at the top row and left picture edge.
    always_comb begin
        top_x  = top_avail_q ? r_data_i[2*W-1:W] : '0;
        top_y  = top_avail_q ? r_data_i[W-1:0] : '0;
        left_x = (mb_x_q != '0) ? left_x_q : '0;
        left_y = (mb_x_q != '0) ? left_y_q : '0;
    end

    cabac_mvd_ctx_calc #(.W(W)) u_ctx_x (
        .abs_a (left_x),
        .abs_b (top_x),
        .ctx   (ctx_x)
    );

    cabac_mvd_ctx_calc #(.W(W)) u_ctx_y (
        .abs_a (left_y),
        .abs_b (top_y),
        .ctx   (ctx_y)
    );

    // Position latch, ctx capture, commit pair and left-neighbour update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mb_x_q      <= '0;
            top_avail_q <= 1'b0;
            left_x_q    <= '0;
            left_y_q    <= '0;
            pair_x_q    <= '0;
            pair_y_q    <= '0;
            ctx_x_q     <= '0;
            ctx_y_q     <= '0;
        end else begin
            if (state_q == IDLE && mb.mb_start_i) begin
                mb_x_q      <= mb.mb_x_i;
                top_avail_q <= (mb.mb_y_i != 16'd0);
            end
            if (state_q == WT) begin
                ctx_x_q <= ctx_x;
                ctx_y_q <= ctx_y;
            end
            if (state_q == OUT && mb.mb_done_i) begin
                if (mb.mvd_zero_i) begin
                    pair_x_q <= '0;
                    pair_y_q <= '0;
                end else begin
                    pair_x_q <= W'(abs_sat(mb.cur_mvd_x_i, SAT_MAX));
                    pair_y_q <= W'(abs_sat(mb.cur_mvd_y_i, SAT_MAX));
                end
            end
            if (state_q == WR) begin
                left_x_q <= pair_x_q;
                left_y_q <= pair_y_q;
            end
        end
    end

    assign mb.nb_valid_o  = (state_q == OUT);
    assign mb.ctx_inc_x_o = ctx_x_q;
    assign mb.ctx_inc_y_o = ctx_y_q;
    assign r_en_o         = (state_q == RD);
    assign r_addr_o       = mb_x_q;
    assign w_en_o         = (state_q == WR);
    assign w_addr_o       = mb_x_q;
    assign w_data_o       = {pair_x_q, pair_y_q};
endmodule

// File: tb/tb_cabac_mvd_nb_ctx.sv
// Bench for cabac_mvd_nb_ctx: directed scenarios plus a randomized raster
// walk checked against an arithmetic model of the neighbour rules.
module tb_cabac_mvd_nb_ctx;
    localparam int W  = 9;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cabac_mvd_nb_ctx_if #(.MEM_TOP_DEPTH(AW)) mb ();

    logic            r_en;
    logic            w_en;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr;
    logic [2*W-1:0]  r_data;
    logic [2*W-1:0]  w_data;

    cabac_mvd_nb_ctx #(.FMV_WIDTH(W-1), .MEM_TOP_DEPTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mb       (mb.slave),
        .r_en_o   (r_en),
        .r_addr_o (r_addr),
        .r_data_i (r_data),
        .w_en_o   (w_en),
        .w_addr_o (w_addr),
        .w_data_o (w_data)
    );

    logic [2*W-1:0] ram [0:(1<<AW)-1];
    logic           pre_en = 1'b0;
    logic [AW-1:0]  pre_addr = '0;
    logic [2*W-1:0] pre_data = '0;

    // Top-row RAM with a backdoor preload port and 1-cycle read latency.
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (w_en) ram[w_addr] <= w_data;
        if (r_en) r_data <= ram[r_addr];
    end

    int checks = 0;
    int errors = 0;
    int mtop_x [0:(1<<AW)-1];
    int mtop_y [0:(1<<AW)-1];
    int mleft_x = 0;
    int mleft_y = 0;

    function automatic int m_abs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 511) ? 511 : a;
    endfunction

    function automatic int m_ctx(input int s);
        if (s < 3) return 0;
        if (s <= 32) return 1;
        return 2;
    endfunction

    function automatic int rnd_mv();
        int v;
        case ($urandom % 4)
            0: v = int'($urandom_range(0, 40));
            1: v = int'($urandom_range(0, 700));
            2: v = int'($urandom_range(0, 32768));
            default: v = 0;
        endcase
        if ($urandom % 2 == 1) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input int x, input int y);
        pre_en = 1'b1;
        pre_addr = AW'(a);
        pre_data = {W'(x), W'(y)};
        tick();
        pre_en = 1'b0;
        mtop_x[a] = x;
        mtop_y[a] = y;
    endtask

    task automatic start_mb(input int x, input int y);
        mb.mb_start_i = 1'b1;
        mb.mb_x_i = AW'(x);
        mb.mb_y_i = 16'(y);
        tick();
        mb.mb_start_i = 1'b0;
    endtask

    task automatic done_mb(input int vx, input int vy, input bit z);
        mb.mb_done_i = 1'b1;
        mb.mvd_zero_i = z;
        mb.cur_mvd_x_i = 16'(vx);
        mb.cur_mvd_y_i = 16'(vy);
        tick();
        mb.mb_done_i = 1'b0;
        mb.mvd_zero_i = 1'b0;
    endtask

    task automatic commit(input int c, input int vx, input int vy, input bit z);
        mtop_x[c] = z ? 0 : m_abs(vx);
        mtop_y[c] = z ? 0 : m_abs(vy);
        mleft_x = mtop_x[c];
        mleft_y = mtop_y[c];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_nb_valid got %b want 0", mb.nb_valid_o);
        end
        checks++;
        if ({r_en, w_en} !== 2'b00) begin
            errors++;
            $display("FAIL reset_en got %b want 00", {r_en, w_en});
        end
        checks++;
        if ({mb.ctx_inc_x_o, mb.ctx_inc_y_o, w_data} !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", {mb.ctx_inc_x_o, mb.ctx_inc_y_o, w_data});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b0 || r_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b%b want 00", mb.nb_valid_o, r_en);
        end
        for (int i = 0; i < (1 << AW); i++) preload(i, 0, 0);
    endtask

    task automatic test_first_fetch();
        start_mb(0, 0);
        checks++;
        if (r_en !== 1'b1 || r_addr !== AW'(0) || mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_t1 got r_en=%b addr=%0d nb=%b want 1 0 0", r_en, r_addr, mb.nb_valid_o);
        end
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b0 || r_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_t2 got nb=%b r_en=%b want 0 0", mb.nb_valid_o, r_en);
        end
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b1 || mb.ctx_inc_x_o !== 2'd0 || mb.ctx_inc_y_o !== 2'd0) begin
            errors++;
            $display("FAIL fetch_t3 got nb=%b ctx=%0d/%0d want 1 0/0", mb.nb_valid_o, mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
    endtask

    task automatic test_row0();
        done_mb(2, -40, 1'b0);
        commit(0, 2, -40, 1'b0);
        checks++;
        if (w_en !== 1'b1 || r_en !== 1'b0 || w_addr !== AW'(0)) begin
            errors++;
            $display("FAIL row0_wr got w_en=%b r_en=%b addr=%0d want 1 0 0", w_en, r_en, w_addr);
        end
        checks++;
        if (w_data !== {9'd2, 9'd40}) begin
            errors++;
            $display("FAIL row0_wdata got %h want %h", w_data, {9'd2, 9'd40});
        end
        tick();
        checks++;
        if (w_en !== 1'b0 || mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL row0_idle got w_en=%b nb=%b want 0 0", w_en, mb.nb_valid_o);
        end
        start_mb(1, 0);
        tick();
        tick();
        checks++;
        if (mb.ctx_inc_x_o !== 2'd0 || mb.ctx_inc_y_o !== 2'd2) begin
            errors++;
            $display("FAIL row0_mb1_ctx got %0d/%0d want 0/2", mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
        done_mb(7, -7, 1'b0);
        commit(1, 7, -7, 1'b0);
        tick();
    endtask

    task automatic test_row1();
        preload(0, 5, 30);
        start_mb(0, 1);
        tick();
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b1 || mb.ctx_inc_x_o !== 2'd1 || mb.ctx_inc_y_o !== 2'd1) begin
            errors++;
            $display("FAIL row1_left_mask got nb=%b ctx=%0d/%0d want 1 1/1", mb.nb_valid_o, mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
    endtask

    task automatic test_boundary();
        preload(1, 511, 511);
        done_mb(-32768, 600, 1'b0);
        commit(0, -32768, 600, 1'b0);
        checks++;
        if (w_data !== {9'd511, 9'd511} || w_addr !== AW'(0)) begin
            errors++;
            $display("FAIL sat_wdata got %h@%0d want %h@0", w_data, w_addr, {9'd511, 9'd511});
        end
        tick();
        start_mb(1, 1);
        tick();
        tick();
        checks++;
        if (mb.ctx_inc_x_o !== 2'd2 || mb.ctx_inc_y_o !== 2'd2) begin
            errors++;
            $display("FAIL sum1022_ctx got %0d/%0d want 2/2", mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
        done_mb(3, -1, 1'b0);
        commit(1, 3, -1, 1'b0);
        tick();
    endtask

    task automatic test_protocol();
        start_mb(2, 1);
        mb.mb_done_i = 1'b1;
        mb.cur_mvd_x_i = 16'sd100;
        mb.cur_mvd_y_i = 16'sd100;
        tick();
        mb.mb_done_i = 1'b0;
        checks++;
        if (w_en !== 1'b0 || mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL done_in_rd got w_en=%b nb=%b want 0 0", w_en, mb.nb_valid_o);
        end
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b1 || mb.ctx_inc_x_o !== 2'd1 || mb.ctx_inc_y_o !== 2'd0) begin
            errors++;
            $display("FAIL proto_ctx got nb=%b ctx=%0d/%0d want 1 1/0", mb.nb_valid_o, mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
        start_mb(5, 0);
        checks++;
        if (mb.nb_valid_o !== 1'b1 || r_en !== 1'b0 || mb.ctx_inc_x_o !== 2'd1 || mb.ctx_inc_y_o !== 2'd0) begin
            errors++;
            $display("FAIL start_in_out got nb=%b r_en=%b ctx=%0d/%0d want 1 0 1/0", mb.nb_valid_o, r_en, mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
        done_mb(-300, 50, 1'b1);
        commit(2, -300, 50, 1'b1);
        checks++;
        if (w_en !== 1'b1 || w_data !== '0 || w_addr !== AW'(2)) begin
            errors++;
            $display("FAIL zero_commit got w_en=%b %h@%0d want 1 0@2", w_en, w_data, w_addr);
        end
        mb.mb_start_i = 1'b1;
        mb.mb_x_i = AW'(3);
        mb.mb_y_i = 16'd1;
        tick();
        mb.mb_start_i = 1'b0;
        tick();
        checks++;
        if (r_en !== 1'b0 || w_en !== 1'b0 || mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL start_in_wr got r_en=%b w_en=%b nb=%b want 0 0 0", r_en, w_en, mb.nb_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        start_mb(3, 1);
        tick();
        tick();
        done_mb(20, 20, 1'b0);
        commit(3, 20, 20, 1'b0);
        tick();
        start_mb(4, 1);
        tick();
        tick();
        mb.mb_done_i = 1'b1;
        mb.cur_mvd_x_i = 16'sd9;
        mb.cur_mvd_y_i = 16'sd9;
        rst_n = 1'b0;
        tick();
        mb.mb_done_i = 1'b0;
        checks++;
        if (mb.nb_valid_o !== 1'b0 || w_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_out got nb=%b w_en=%b want 0 0", mb.nb_valid_o, w_en);
        end
        rst_n = 1'b1;
        mleft_x = 0;
        mleft_y = 0;
        tick();
        checks++;
        if (w_en !== 1'b0 || mb.nb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got w_en=%b nb=%b want 0 0", w_en, mb.nb_valid_o);
        end
        start_mb(1, 1);
        checks++;
        if (r_en !== 1'b1 || r_addr !== AW'(1)) begin
            errors++;
            $display("FAIL refetch_rd got r_en=%b addr=%0d want 1 1", r_en, r_addr);
        end
        tick();
        tick();
        checks++;
        if (mb.nb_valid_o !== 1'b1 || mb.ctx_inc_x_o !== 2'd1 || mb.ctx_inc_y_o !== 2'd0) begin
            errors++;
            $display("FAIL refetch_ctx got nb=%b ctx=%0d/%0d want 1 1/0", mb.nb_valid_o, mb.ctx_inc_x_o, mb.ctx_inc_y_o);
        end
        done_mb(0, 0, 1'b1);
        commit(1, 0, 0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        int vx;
        int vy;
        int ex;
        int ey;
        int lx;
        int ly;
        bit z;
        for (int y = 2; y < 10; y++) begin
            for (int x = 0; x < 6; x++) begin
                lx = (x == 0) ? 0 : mleft_x;
                ly = (x == 0) ? 0 : mleft_y;
                ex = m_ctx(lx + mtop_x[x]);
                ey = m_ctx(ly + mtop_y[x]);
                start_mb(x, y);
                checks++;
                if (r_en !== 1'b1 || r_addr !== AW'(x)) begin
                    errors++;
                    $display("FAIL rnd_rd(%0d,%0d) got r_en=%b addr=%0d want 1 %0d", x, y, r_en, r_addr, x);
                end
                tick();
                tick();
                checks++;
                if (mb.nb_valid_o !== 1'b1 || mb.ctx_inc_x_o !== 2'(ex) || mb.ctx_inc_y_o !== 2'(ey)) begin
                    errors++;
                    $display("FAIL rnd_ctx(%0d,%0d) got nb=%b ctx=%0d/%0d want 1 %0d/%0d", x, y, mb.nb_valid_o, mb.ctx_inc_x_o, mb.ctx_inc_y_o, ex, ey);
                end
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
                vx = rnd_mv();
                vy = rnd_mv();
                z = ($urandom % 5 == 0);
                done_mb(vx, vy, z);
                commit(x, vx, vy, z);
                checks++;
                if (w_en !== 1'b1 || w_addr !== AW'(x) || w_data !== 18'(mtop_x[x] * 512 + mtop_y[x])) begin
                    errors++;
                    $display("FAIL rnd_wr(%0d,%0d) got w_en=%b %h@%0d want 1 %h@%0d", x, y, w_en, w_data, w_addr, 18'(mtop_x[x] * 512 + mtop_y[x]), x);
                end
                tick();
            end
        end
    endtask

    initial begin
        mb.mb_start_i = 1'b0;
        mb.mb_x_i = '0;
        mb.mb_y_i = '0;
        mb.mb_done_i = 1'b0;
        mb.mvd_zero_i = 1'b0;
        mb.cur_mvd_x_i = '0;
        mb.cur_mvd_y_i = '0;
        test_reset();
        test_first_fetch();
        test_row0();
        test_row1();
        test_boundary();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
